// File: rtl/program_loader.sv
// program_loader: byte-serial boot loader for the CPU instruction memory.
// Parses SYNC, LEN, LEN payload bytes (LEN = 0 means 256) and writes the
// payload to consecutive addresses from 0, keeping the CPU in reset until a
// complete frame has been written and verified.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN adds a trailing CSUM byte,
// which must equal (LEN + sum of payload) mod 256.
module program_loader #(
   parameter logic [7:0] SYNC = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       imem_we,
   output logic [7:0] imem_addr,
   output logic [7:0] imem_wdata,
   output logic       cpu_hold,
   output logic       load_done,
   output logic       load_error
);

   typedef enum logic [2:0] {
      ST_SYNC   = 3'd0,
      ST_LEN    = 3'd1,
      ST_DATA   = 3'd2,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CSUM   = 3'd3,
`endif
      ST_VERIFY = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERR    = 3'd6
   } state_e;

   // Modulo-256 accumulation used for the frame checksum.
   function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

   state_e     state_q, state_d;
   logic [8:0] count_q, count_d;
   logic [7:0] index_q, index_d;
   logic [7:0] sum_q, sum_d;
   logic       we_q, we_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       hold_q, hold_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic       match_q, match_d;
`endif
   logic       in_ready_s;
   logic       accept_s;

   // Handshake: the loader is ready everywhere except the VERIFY cycle and reset.
   always_comb begin
      in_ready_s = 1'b0;
      accept_s   = 1'b0;
      in_ready_s = !reset && (state_q != ST_VERIFY);
      accept_s   = in_valid && in_ready_s;
   end

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      index_d = index_q;
      sum_d   = sum_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      match_d = match_q;
`endif
      case (state_q)
         ST_SYNC, ST_DONE, ST_ERR: begin
            // Non-SYNC bytes are swallowed; SYNC starts a new frame.
            if (accept_s && (in_data == SYNC)) begin
               state_d = ST_LEN;
            end else begin
               state_d = state_q;
            end
         end
         ST_LEN: begin
            if (accept_s) begin
               count_d = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
               sum_d   = in_data;
               index_d = 8'h00;
               state_d = ST_DATA;
            end else begin
               state_d = ST_LEN;
            end
         end
         ST_DATA: begin
            if (accept_s) begin
               we_d    = 1'b1;
               addr_d  = index_q;
               wdata_d = in_data;
               index_d = index_q + 8'd1;
               sum_d   = csum_add(sum_q, in_data);
               count_d = count_q - 9'd1;
               if (count_q == 9'd1) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  state_d = ST_CSUM;
`else
                  state_d = ST_VERIFY;
`endif
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               state_d = ST_DATA;
            end
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         ST_CSUM: begin
            if (accept_s) begin
               match_d = (in_data == sum_q);
               state_d = ST_VERIFY;
            end else begin
               state_d = ST_CSUM;
            end
         end
`endif
         ST_VERIFY: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_d = match_q ? ST_DONE : ST_ERR;
`else
            state_d = ST_DONE;
`endif
         end
         default: begin
            state_d = ST_SYNC;
         end
      endcase

      // Status flags follow the state being entered so they settle one cycle after VERIFY.
      hold_d = (state_d != ST_DONE);
      done_d = (state_d == ST_DONE);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      err_d  = (state_d == ST_ERR);
`else
      err_d  = 1'b0;
`endif
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_SYNC;
         count_q <= 9'd0;
         index_q <= 8'h00;
         sum_q   <= 8'h00;
         we_q    <= 1'b0;
         addr_q  <= 8'h00;
         wdata_q <= 8'h00;
         hold_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         match_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         index_q <= index_d;
         sum_q   <= sum_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         match_q <= match_d;
`endif
      end
   end

   assign in_ready   = in_ready_s;
   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_hold   = hold_q;
   assign load_done  = done_q;
   assign load_error = err_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed and randomized frames checked against a
// frame-level reference model (expected writes = payload at index i,
// expected status from checksum arithmetic).
module tb_program_loader;

   localparam logic [7:0] SYNC_B = 8'hA5;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       imem_we;
   logic [7:0] imem_addr;
   logic [7:0] imem_wdata;
   logic       cpu_hold;
   logic       load_done;
   logic       load_error;

   int checks = 0;
   int errors = 0;

   logic [7:0] pl[$];

   always #5 clk = ~clk;

   program_loader #(.SYNC(SYNC_B)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .load_done  (load_done),
      .load_error (load_error)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle starting just after a negedge: drive, check ready, then check the write result.
   task automatic cyc(input logic v, input logic [7:0] d, input logic exp_rdy,
                      input logic exp_we, input logic [7:0] ea, input logic [7:0] ed);
      in_valid = v;
      in_data  = d;
      #1;
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      @(negedge clk);
      #1;
      chk("imem_we", {31'd0, imem_we}, {31'd0, exp_we});
      if (exp_we) begin
         chk("imem_addr", {24'd0, imem_addr}, {24'd0, ea});
         chk("imem_wdata", {24'd0, imem_wdata}, {24'd0, ed});
      end
   endtask

   task automatic gap(input bit gaps);
      int n;
      n = gaps ? $urandom_range(0, 2) : 0;
      for (int k = 0; k < n; k++) cyc(1'b0, 8'($urandom), 1'b1, 1'b0, 8'h00, 8'h00);
   endtask

   // Sends a whole frame and checks the writes, the VERIFY cycle and the final status.
   task automatic send_frame(input logic [7:0] len, input logic [7:0] p[$],
                             input logic [7:0] cs, input bit gaps);
      int n;
      int s;
      bit ok;
      n = (len == 8'h00) ? 256 : int'(len);
      s = int'(len);
      gap(gaps);
      cyc(1'b1, SYNC_B, 1'b1, 1'b0, 8'h00, 8'h00);
      chk("hold_after_sync", {31'd0, cpu_hold}, 32'd1);
      chk("done_after_sync", {31'd0, load_done}, 32'd0);
      chk("error_after_sync", {31'd0, load_error}, 32'd0);
      gap(gaps);
      cyc(1'b1, len, 1'b1, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < n; i++) begin
         gap(gaps);
         cyc(1'b1, p[i], 1'b1, 1'b1, i[7:0], p[i]);
         s = s + int'(p[i]);
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      gap(gaps);
      cyc(1'b1, cs, 1'b1, 1'b0, 8'h00, 8'h00);
      ok = (cs == s[7:0]);
`else
      ok = 1'b1;
`endif
      chk("hold_in_verify", {31'd0, cpu_hold}, 32'd1);
      // VERIFY cycle: a SYNC offered here must be refused
      cyc(1'b1, SYNC_B, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("cpu_hold_final", {31'd0, cpu_hold}, {31'd0, !ok});
      chk("load_done_final", {31'd0, load_done}, {31'd0, ok});
      chk("load_error_final", {31'd0, load_error}, {31'd0, !ok});
      in_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] len;
      logic [7:0] cs;
      int         sum;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      @(negedge clk);
      #1;
      chk("ready_in_reset", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_we", {31'd0, imem_we}, 32'd0);
      chk("rst_addr", {24'd0, imem_addr}, 32'd0);
      chk("rst_wdata", {24'd0, imem_wdata}, 32'd0);
      chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
      chk("rst_done", {31'd0, load_done}, 32'd0);
      chk("rst_error", {31'd0, load_error}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);

      // basic frame, back-to-back
      pl = {8'h11, 8'h22, 8'h33};
      send_frame(8'h03, pl, 8'h69, 1'b0);

      // bad checksum, then a good frame
      send_frame(8'h03, pl, 8'h00, 1'b0);
      send_frame(8'h03, pl, 8'h69, 1'b0);

      // junk before sync
      cyc(1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00);
      cyc(1'b1, 8'hFF, 1'b1, 1'b0, 8'h00, 8'h00);
      cyc(1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 8'h00);
      pl = {8'h7E};
      send_frame(8'h01, pl, 8'h7F, 1'b0);

      // LEN = 0 means 256 bytes
      pl = {};
      for (int i = 0; i < 256; i++) pl.push_back(i[7:0]);
      send_frame(8'h00, pl, 8'h80, 1'b0);

      // first frame with random gaps
      pl = {8'h11, 8'h22, 8'h33};
      send_frame(8'h03, pl, 8'h69, 1'b1);

      // random frames, some with corrupted checksums
      for (int f = 0; f < 6; f++) begin
         len = 8'($urandom_range(1, 20));
         pl  = {};
         sum = int'(len);
         for (int i = 0; i < int'(len); i++) begin
            pl.push_back(8'($urandom));
            sum = sum + int'(pl[i]);
         end
         cs = sum[7:0];
         if ($urandom_range(0, 1) == 1) cs = cs ^ 8'($urandom_range(1, 255));
         send_frame(len, pl, cs, 1'b1);
      end

      // reset mid-frame after 2 of 3 payload bytes
      cyc(1'b1, SYNC_B, 1'b1, 1'b0, 8'h00, 8'h00);
      cyc(1'b1, 8'h03, 1'b1, 1'b0, 8'h00, 8'h00);
      cyc(1'b1, 8'h11, 1'b1, 1'b1, 8'h00, 8'h11);
      cyc(1'b1, 8'h22, 1'b1, 1'b1, 8'h01, 8'h22);
      reset    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h33;
      #1;
      chk("ready_mid_reset", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mid_rst_we", {31'd0, imem_we}, 32'd0);
      chk("mid_rst_addr", {24'd0, imem_addr}, 32'd0);
      chk("mid_rst_wdata", {24'd0, imem_wdata}, 32'd0);
      chk("mid_rst_hold", {31'd0, cpu_hold}, 32'd1);
      chk("mid_rst_done", {31'd0, load_done}, 32'd0);
      chk("mid_rst_error", {31'd0, load_error}, 32'd0);
      // loader is back in SYNC: these bytes are discarded
      cyc(1'b1, 8'h33, 1'b1, 1'b0, 8'h00, 8'h00);
      cyc(1'b1, 8'h03, 1'b1, 1'b0, 8'h00, 8'h00);
      cyc(1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 8'h00);
      chk("hold_waiting", {31'd0, cpu_hold}, 32'd1);
      pl = {8'h11, 8'h22, 8'h33};
      send_frame(8'h03, pl, 8'h69, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/program_loader.md
# program_loader

Byte-serial boot loader that fills the CPU's writable instruction memory before execution. It accepts a framed byte stream (sync, length, payload, optional checksum) over a valid/ready handshake and writes payload bytes to consecutive instruction addresses from 0. It drives `cpu_hold` to keep the CPU in reset until a complete frame has been written and verified. It sits between the host link and the instruction-memory write port, alongside the CPU's fetch port.

## Interface
Parameters:
- `SYNC`, 8'hA5, frame start byte.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction-memory write strobe, one-cycle pulse.
- `imem_addr`  out  8  instruction-memory write address.
- `imem_wdata`  out  8  instruction byte to write.
- `cpu_hold`  out  1  high while the CPU must stay in reset.
- `load_done`  out  1  high after a successful load, until the next `SYNC` is accepted.
- `load_error`  out  1  high after a failed checksum, until the next `SYNC` is accepted.

## Operation
- A byte is accepted on any cycle with `in_valid && in_ready`.
- Frame format: `SYNC`, `LEN`, `LEN` payload bytes, `CSUM` (CSUM only with the macro). `LEN` = 0 means 256 bytes.
- States: SYNC, LEN, DATA, CSUM, VERIFY, DONE, ERR. Reset enters SYNC.
- SYNC: non-`SYNC` bytes are accepted and discarded. A `SYNC` byte goes to LEN and clears `load_done` and `load_error`.
- LEN: the accepted byte loads the 9-bit remaining count (0 becomes 256). The running sum is set to the byte. Index is cleared to 0. Go to DATA.
- DATA: each accepted byte produces a write at `imem_addr` = index, `imem_wdata` = byte. Index increments; index wraps 255 -> 0 only after the 256th byte. The byte is added mod 256 into the sum, and the count decrements. When the count reaches 0, go to CSUM (macro defined) or VERIFY (macro undefined).
- CSUM: the accepted byte is compared with the sum. Go to VERIFY.
- VERIFY: lasts one cycle with `in_ready` = 0. Then go to DONE (match, or macro undefined) or ERR (mismatch).
- DONE: `cpu_hold` = 0, `load_done` = 1.
- ERR: `cpu_hold` = 1, `load_error` = 1. Already-written memory is not erased.
- In DONE and ERR, bytes are accepted. Non-`SYNC` bytes are discarded. A `SYNC` byte reasserts `cpu_hold` on the next cycle and goes to LEN.
- `in_ready` = 1 in every state except VERIFY, and except while `reset` is high.
- `cpu_hold` = 1 in every state except DONE.

## Timing
- Reset values (cycle after `reset` is sampled high): `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0, `cpu_hold` = 1, `load_done` = 0, `load_error` = 0, state SYNC. `in_ready` is 0 during reset and 1 on the first cycle after it.
- Write outputs are registered: a payload byte accepted at cycle t gives `imem_we` = 1 at t+1 with address and data valid. `imem_addr` and `imem_wdata` hold their values between writes.
- Back-to-back bytes give back-to-back write pulses. Gaps in `in_valid` insert no extra cycles beyond the gap.
- Final byte (CSUM, or last payload byte without the macro) accepted at t: VERIFY at t+1, final `imem_we` at t+1, and `cpu_hold`/`load_done`/`load_error` update at t+2.
- Reset mid-frame aborts immediately and returns all outputs to their reset values. No write is issued for a byte accepted in the reset cycle.

## Configuration
- `PROGRAM_LOADER_CHECKSUM_EN` defined: a CSUM byte is expected after the payload. Its required value is (LEN + sum of payload) mod 256. A mismatch goes to ERR.
- Undefined: there is no CSUM state, ERR is unreachable, and `load_error` is tied to 0. The frame completes after the last payload byte.

## Test plan
- Reset, then stream A5,03,11,22,33,69 -> writes (0,11),(1,22),(2,33) on consecutive cycles; `load_done` = 1 and `cpu_hold` = 0 two cycles after the 69 is accepted.
- Same frame with CSUM 00 -> three writes, `load_error` = 1, `cpu_hold` stays 1; a following valid frame then completes with `load_error` cleared.
- Bytes 00,FF,5A before A5,01,7E,7F -> no writes for the junk bytes; a single write (0,7E); done.
- LEN = 00 with payload 00..FF and CSUM 80 -> 256 writes to addresses 0..255, last write (FF,FF); done.
- `reset` asserted after 2 of 3 payload bytes, then byte 33 -> no write for the 33; outputs at reset values; the loader waits for A5.
- Random `in_valid` gaps on the first scenario's frame -> identical write sequence; `in_ready` = 0 exactly during the VERIFY cycle.
